// File: rtl/systolic_2x2_drain_if.sv
// Result stream from the 2x2 systolic drain toward the LSTM datapath.
// The master drives a word plus its tag fields; the slave returns m_ready.
interface systolic_2x2_drain_if #(
    parameter int acc_width = 16
) ();
    logic                 m_valid;
    logic                 m_ready;
    logic [acc_width-1:0] m_data;
    logic [1:0]           m_idx;
    logic                 m_last;
    logic                 m_buf;

    modport master (
        output m_valid,
        output m_data,
        output m_idx,
        output m_last,
        output m_buf,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_idx,
        input  m_last,
        input  m_buf,
        output m_ready
    );
endinterface

// File: rtl/systolic_2x2_drain.sv
// Snapshots the just-completed 2x2 output buffer on each active_buffer toggle and streams c00..c11.
// Optional saturating drop counter (ovr_count) is enabled by defining SYSTOLIC_DRAIN_OVR_CNT_EN.
module systolic_2x2_drain #(
    parameter int data_width = 8,
    parameter int acc_width  = 2 * data_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [acc_width-1:0] buf_c00_0,
    input  logic [acc_width-1:0] buf_c01_0,
    input  logic [acc_width-1:0] buf_c10_0,
    input  logic [acc_width-1:0] buf_c11_0,
    input  logic [acc_width-1:0] buf_c00_1,
    input  logic [acc_width-1:0] buf_c01_1,
    input  logic [acc_width-1:0] buf_c10_1,
    input  logic [acc_width-1:0] buf_c11_1,
    input  logic                 active_buffer,
    systolic_2x2_drain_if.master m,
    output logic                 overrun
`ifdef SYSTOLIC_DRAIN_OVR_CNT_EN
    ,
    output logic [7:0]           ovr_count
`endif
);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    state_t               state_r, state_n;
    logic                 ab_q_r;
    logic [acc_width-1:0] snap_r [4];
    logic [acc_width-1:0] snap_n [4];
    logic [acc_width-1:0] cap_s  [4];
    logic [1:0]           idx_r, idx_n;
    logic                 valid_r, valid_n;
    logic [acc_width-1:0] data_r, data_n;
    logic                 last_r, last_n;
    logic                 buf_r, buf_n;
    logic                 overrun_r, overrun_n;
    logic                 toggle_s, hs_s, capture_s;

    assign toggle_s = (active_buffer != ab_q_r);
    assign hs_s     = valid_r && m.m_ready;

    // The finished buffer is the one the array just left, i.e. ab_q_r.
    assign cap_s[0] = ab_q_r ? buf_c00_1 : buf_c00_0;
    assign cap_s[1] = ab_q_r ? buf_c01_1 : buf_c01_0;
    assign cap_s[2] = ab_q_r ? buf_c10_1 : buf_c10_0;
    assign cap_s[3] = ab_q_r ? buf_c11_1 : buf_c11_0;

    // Next-state and next-output decode for the drain FSM.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        valid_n   = valid_r;
        buf_n     = buf_r;
        capture_s = 1'b0;
        overrun_n = 1'b0;
        case (state_r)
            IDLE: begin
                valid_n = 1'b0;
                if (toggle_s) begin
                    capture_s = 1'b1;
                    idx_n     = 2'd0;
                    valid_n   = 1'b1;
                    buf_n     = ab_q_r;
                    state_n   = DRAIN;
                end else begin
                    state_n   = IDLE;
                end
            end
            DRAIN: begin
                if (hs_s && (idx_r == 2'd3)) begin
                    idx_n = 2'd0;
                    if (toggle_s) begin
                        // Back-to-back frame: reload without a bubble.
                        capture_s = 1'b1;
                        buf_n     = ab_q_r;
                        state_n   = DRAIN;
                    end else begin
                        valid_n   = 1'b0;
                        state_n   = IDLE;
                    end
                end else begin
                    overrun_n = toggle_s;
                    if (hs_s) begin
                        idx_n = idx_r + 2'd1;
                    end else begin
                        idx_n = idx_r;
                    end
                end
            end
            default: begin
                valid_n = 1'b0;
                idx_n   = 2'd0;
                state_n = IDLE;
            end
        endcase
    end

    // Snapshot mux and registered word selection.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (capture_s) begin
                snap_n[i] = cap_s[i];
            end else begin
                snap_n[i] = snap_r[i];
            end
        end
        data_n = snap_n[idx_n];
        last_n = valid_n && (idx_n == 2'd3);
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ab_q_r    <= 1'b0;
            idx_r     <= 2'd0;
            valid_r   <= 1'b0;
            data_r    <= '0;
            last_r    <= 1'b0;
            buf_r     <= 1'b0;
            overrun_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= '0;
            end
        end else begin
            state_r   <= state_n;
            ab_q_r    <= active_buffer;
            idx_r     <= idx_n;
            valid_r   <= valid_n;
            data_r    <= data_n;
            last_r    <= last_n;
            buf_r     <= buf_n;
            overrun_r <= overrun_n;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= snap_n[i];
            end
        end
    end

    assign m.m_valid = valid_r;
    assign m.m_data  = data_r;
    assign m.m_idx   = idx_r;
    assign m.m_last  = last_r;
    assign m.m_buf   = buf_r;
    assign overrun   = overrun_r;

`ifdef SYSTOLIC_DRAIN_OVR_CNT_EN
    logic [7:0] ovr_count_r;

    // Saturating count of dropped frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_count_r <= 8'd0;
        end else if (overrun_n && (ovr_count_r != 8'hFF)) begin
            ovr_count_r <= ovr_count_r + 8'd1;
        end else begin
            ovr_count_r <= ovr_count_r;
        end
    end

    assign ovr_count = ovr_count_r;
`endif

endmodule

// File: tb/tb_systolic_2x2_drain.sv
// Self-checking bench for systolic_2x2_drain: frame table plus hand-written corner sequences,
// with a scoreboard queue of expected stream words popped on every handshake.
module tb_systolic_2x2_drain;
    localparam int DW = 8;
    localparam int AW = 2 * DW;

    logic          clk;
    logic          rst;
    logic          ab;
    logic          ovr;
    logic [AW-1:0] b0 [4];
    logic [AW-1:0] b1 [4];
`ifdef SYSTOLIC_DRAIN_OVR_CNT_EN
    logic [7:0]    ovr_count;
`endif

    systolic_2x2_drain_if #(.acc_width(AW)) bus ();

    systolic_2x2_drain #(.data_width(DW), .acc_width(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .buf_c00_0     (b0[0]),
        .buf_c01_0     (b0[1]),
        .buf_c10_0     (b0[2]),
        .buf_c11_0     (b0[3]),
        .buf_c00_1     (b1[0]),
        .buf_c01_1     (b1[1]),
        .buf_c10_1     (b1[2]),
        .buf_c11_1     (b1[3]),
        .active_buffer (ab),
        .m             (bus),
        .overrun       (ovr)
`ifdef SYSTOLIC_DRAIN_OVR_CNT_EN
        ,
        .ovr_count     (ovr_count)
`endif
    );

    typedef struct {
        logic [AW-1:0] data;
        logic [1:0]    idx;
        logic          last;
        logic          bsel;
    } word_t;

    // c is packed as {c11, c10, c01, c00}; c[0] is c00.
    typedef struct {
        logic                bsel;
        logic [3:0][AW-1:0]  c;
        int                  stall;
        bit                  scribble;
        logic                exp_buf;
    } frame_t;

    word_t  q[$];
    frame_t tbl[4];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     ovr_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (ovr) ovr_seen++;
            if (bus.m_valid && bus.m_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", {14'd0, bus.m_idx, bus.m_data}, 32'hFFFFFFFF);
                end else begin
                    word_t e;
                    e = q.pop_front();
                    chk("sb_data", bus.m_data, e.data);
                    chk("sb_idx",  bus.m_idx,  e.idx);
                    chk("sb_last", bus.m_last, e.last);
                    chk("sb_buf",  bus.m_buf,  e.bsel);
                end
            end
        end
    end

    task automatic set_buf(input logic bsel, input logic [3:0][AW-1:0] c);
        for (int i = 0; i < 4; i++) begin
            if (bsel) b1[i] = c[i];
            else      b0[i] = c[i];
        end
    endtask

    task automatic push_frame(input logic [3:0][AW-1:0] c, input logic bsel);
        for (int i = 0; i < 4; i++) begin
            q.push_back('{data: c[i], idx: 2'(i), last: (i == 3), bsel: bsel});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        chk("drain_done", q.size(), 32'd0);
        chk("idle_valid", bus.m_valid, 1'b0);
    endtask

    task automatic run_frame(input frame_t f);
        set_buf(f.bsel, f.c);
        bus.m_ready = (f.stall == 0);
        ab = ~ab;
        push_frame(f.c, f.exp_buf);
        step();
        chk("lat_valid", bus.m_valid, 1'b1);
        chk("lat_idx",   bus.m_idx,   2'd0);
        chk("lat_data",  bus.m_data,  f.c[0]);
        if (f.scribble) set_buf(f.bsel, ~f.c);
        for (int s = 0; s < f.stall; s++) begin
            step();
            chk("hold_valid", bus.m_valid, 1'b1);
            chk("hold_idx",   bus.m_idx,   2'd0);
            chk("hold_data",  bus.m_data,  f.c[0]);
            chk("hold_buf",   bus.m_buf,   f.exp_buf);
        end
        bus.m_ready = 1'b1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][AW-1:0] fr;

        tbl[0] = '{bsel: 1'b0, c: {16'd4, 16'd3, 16'd2, 16'd1}, stall: 0, scribble: 1'b0, exp_buf: 1'b0};
        tbl[1] = '{bsel: 1'b1, c: {16'h0001, 16'h8000, 16'hFFFF, 16'h00FF}, stall: 0, scribble: 1'b1, exp_buf: 1'b1};
        tbl[2] = '{bsel: 1'b0, c: {16'd4, 16'd3, 16'd2, 16'd1}, stall: 5, scribble: 1'b0, exp_buf: 1'b0};
        tbl[3] = '{bsel: 1'b1, c: {16'h1234, 16'hA5A5, 16'h5A5A, 16'hBEEF}, stall: 2, scribble: 1'b1, exp_buf: 1'b1};

        rst = 1'b1;
        ab  = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b0[i] = '0;
            b1[i] = '0;
        end
        step();
        step();
        chk("rst_valid",   bus.m_valid, 1'b0);
        chk("rst_data",    bus.m_data,  16'd0);
        chk("rst_idx",     bus.m_idx,   2'd0);
        chk("rst_last",    bus.m_last,  1'b0);
        chk("rst_buf",     bus.m_buf,   1'b0);
        chk("rst_overrun", ovr,         1'b0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_no_toggle", bus.m_valid, 1'b0);
`ifdef SYSTOLIC_DRAIN_OVR_CNT_EN
        chk("ovr_count_rst", ovr_count, 8'd0);
`endif

        for (int t = 0; t < 4; t++) run_frame(tbl[t]);

        // Stalled consumer sees a second toggle: that frame is dropped.
        fr = {16'd14, 16'd13, 16'd12, 16'd11};
        set_buf(1'b0, fr);
        bus.m_ready = 1'b0;
        ab = ~ab;
        push_frame(fr, 1'b0);
        repeat (3) step();
        set_buf(1'b1, {16'd24, 16'd23, 16'd22, 16'd21});
        ab = ~ab;
        step();
        chk("ovr_pulse", ovr, 1'b1);
        chk("ovr_keep_idx", bus.m_idx, 2'd0);
        chk("ovr_keep_data", bus.m_data, 16'd11);
`ifdef SYSTOLIC_DRAIN_OVR_CNT_EN
        chk("ovr_count_one", ovr_count, 8'd1);
`endif
        step();
        chk("ovr_one_cycle", ovr, 1'b0);
        bus.m_ready = 1'b1;
        drain();
        repeat (4) step();
        chk("ovr_no_replay", bus.m_valid, 1'b0);

        // Toggle lands on the final handshake: next frame follows with no bubble.
        fr = {16'd34, 16'd33, 16'd32, 16'd31};
        set_buf(1'b0, fr);
        bus.m_ready = 1'b1;
        ab = ~ab;
        push_frame(fr, 1'b0);
        repeat (4) step();
        chk("b2b_at_last", bus.m_idx, 2'd3);
        fr = {16'd6, 16'd7, 16'd8, 16'd9};
        set_buf(1'b1, fr);
        ab = ~ab;
        push_frame(fr, 1'b1);
        step();
        chk("b2b_valid",   bus.m_valid, 1'b1);
        chk("b2b_idx",     bus.m_idx,   2'd0);
        chk("b2b_data",    bus.m_data,  16'd9);
        chk("b2b_buf",     bus.m_buf,   1'b1);
        chk("b2b_no_ovr",  ovr,         1'b0);
        drain();

        // Asynchronous reset in the middle of a frame.
        fr = {16'd44, 16'd43, 16'd42, 16'd41};
        set_buf(1'b0, fr);
        ab = ~ab;
        push_frame(fr, 1'b0);
        repeat (3) step();
        chk("mid_idx", bus.m_idx, 2'd2);
        #1;
        rst = 1'b1;
        ab  = 1'b0;
        #1;
        chk("async_rst_valid", bus.m_valid, 1'b0);
        q.delete();
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("post_rst_quiet", bus.m_valid, 1'b0);

        run_frame('{bsel: 1'b0, c: {16'd54, 16'd53, 16'd52, 16'd51}, stall: 1, scribble: 1'b0, exp_buf: 1'b0});

        chk("ovr_total", ovr_seen, 32'd1);
        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_2x2_drain.md
Name: systolic_2x2_drain

Overview:
- Read-side companion to the 2x2 systolic array.
- Watches the array's `active_buffer` toggle and snapshots the buffer that just completed: the one now inactive, i.e. the previous `active_buffer` value.
- Serialises its four results c00, c01, c10, c11 onto a valid/ready stream toward the LSTM datapath.
- Flags frames lost when the consumer stalls past the next toggle.

Parameters:
- data_width, 8, element width of the array's A/B operands; used only to derive acc_width.
- acc_width, 2*data_width, width of each result word and of m_data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- buf_c00_0, buf_c01_0, buf_c10_0, buf_c11_0  in  acc_width each  array output buffer 0.
- buf_c00_1, buf_c01_1, buf_c10_1, buf_c11_1  in  acc_width each  array output buffer 1.
- active_buffer  in  1  buffer currently being written by the array.
- m_valid  out  1  result word available.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready at a clk edge.
- m_data  out  acc_width  result word.
- m_idx  out  2  element index: 0=c00, 1=c01, 2=c10, 3=c11.
- m_last  out  1  high with m_idx==3.
- m_buf  out  1  buffer number the current frame was taken from.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (async, rst=1): immediately clears the following.
  - Outputs: m_valid=0, m_data=0, m_idx=0, m_last=0, m_buf=0, overrun=0.
  - State: state=IDLE, ab_q=0, all four snapshot registers=0.
- ab_q is updated to active_buffer every cycle.
- Toggle: toggle = (active_buffer != ab_q), sampled at a clk edge.
- Capture: on an accepted toggle, load the 4 snapshot registers from buffer ab_q (the buffer just finished); set m_buf=ab_q.
- Latency: active_buffer changes after edge E; the capture happens at edge E+1; m_valid=1 with m_idx=0 from E+1 onward.
- FSM IDLE:
  - m_valid=0.
  - Toggle -> capture, idx=0, go DRAIN.
- FSM DRAIN:
  - m_valid=1; m_data=snapshot[idx]; m_last=(idx==3).
  - Handshake with idx<3 -> idx+1.
  - Handshake with idx==3 and no toggle -> IDLE, m_valid=0 next cycle.
  - Handshake with idx==3 and a simultaneous toggle -> capture the new frame, idx=0, stay in DRAIN. No overrun, no bubble.
- Toggle in DRAIN with no final handshake that cycle:
  - The new frame is dropped; the current frame continues undisturbed.
  - overrun=1 for exactly that cycle.
- Stream rules:
  - m_data, m_idx, m_last and m_buf hold stable while m_valid && !m_ready.
  - m_valid never deasserts without a handshake, except on rst.
- Snapshot isolation: later changes on buf_* inputs never alter an in-flight frame.
- Data: results pass through bit-exact; no arithmetic or width change.
- Throughput: 4 words per frame at 1 word/cycle when m_ready is held high. The array's frame period (≥16 cycles) never overruns a non-stalling consumer.
- Reset mid-frame: the frame is discarded and no further words are emitted. After release, the first toggle is detected relative to ab_q=0, matching the array's reset value.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_OVR_CNT_EN.
- Defined:
  - Adds output port ovr_count (out, 8 bits).
  - Increments on each overrun pulse and saturates at 255.
  - Clears on rst.
- Undefined: no ovr_count port and no counter logic; the overrun pulse still exists.

Test Plan:
- Reset release, buffer 0 = {c00=1, c01=2, c10=3, c11=4}, m_ready=1, active_buffer 0->1 -> at E+1..E+4 stream 1,2,3,4 with m_idx 0..3, m_last only on 4, m_buf=0; m_valid=0 at E+5.
- Same frame with m_ready=0 for 5 cycles, then 1 -> word 1 with m_idx=0 held stable all 5 cycles; no word lost or repeated.
- Frame captured from buffer 1 = {0x00FF, 0xFFFF, 0x8000, 0x0001}; overwrite buf_c*_1 inputs mid-drain -> output stays 0x00FF, 0xFFFF, 0x8000, 0x0001; m_buf=1.
- m_ready=0 whole frame, second toggle arrives -> overrun high exactly 1 cycle; old frame drains intact; dropped frame never appears; ovr_count=1 when the macro is defined.
- Toggle in the same cycle as the idx==3 handshake, new frame {9,8,7,6} -> next cycle m_valid=1, m_idx=0, m_data=9; overrun stays 0.
- rst asserted during m_idx=2, asynchronously between edges -> m_valid=0 immediately; after release, no words until the next active_buffer toggle.
